// File: rtl/conv_code_pkg.sv
// Shared code definitions for the rate-1/2 convolutional link (encoder and decoder).
// Holds the default generators, the soft-value encoding and the encoder state enum.
package conv_code_pkg;

    localparam int         CONV_K  = 7;
    localparam logic [6:0] CONV_G1 = 7'o171;
    localparam logic [6:0] CONV_G2 = 7'o133;

    localparam logic [2:0] SOFT_ZERO = 3'b000;
    localparam logic [2:0] SOFT_ONE  = 3'b111;

    typedef enum logic {
        ST_DATA = 1'b0,
        ST_TAIL = 1'b1
    } enc_state_t;

    function automatic logic [2:0] soft_map(input logic coded);
        return coded ? SOFT_ONE : SOFT_ZERO;
    endfunction

    // v and the generators are zero-extended so any K up to 32 fits
    function automatic logic [5:0] coded_word(input logic [31:0] v,
                                              input logic [31:0] g1,
                                              input logic [31:0] g2);
        logic c1;
        logic c2;
        c1 = ^(v & g1);
        c2 = ^(v & g2);
        return {soft_map(c2), soft_map(c1)};
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Convolutional encoder shift register and parity taps.
// c1/c2 are combinational from the current bit b and the stored history.
module conv_enc_core
    import conv_code_pkg::*;
#(
    parameter int         K  = CONV_K,
    parameter logic [K-1:0] G1 = CONV_G1,
    parameter logic [K-1:0] G2 = CONV_G2
) (
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  logic b,
    input  logic clear,
    output logic c1,
    output logic c2
);

    logic [K-2:0] r_sr;
    logic [K-1:0] w_v;

    assign w_v = {b, r_sr};
    assign c1  = ^(w_v & G1);
    assign c2  = ^(w_v & G2);

    // newest bit enters at the top; clear takes priority over a shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr <= '0;
        end else if (clear) begin
            r_sr <= '0;
        end else if (step) begin
            r_sr <= {b, r_sr[K-2:1]};
        end
    end

endmodule

// File: rtl/viterbi_encoder_stream.sv
// Streaming rate-1/2 convolutional encoder with per-frame zero tail and a
// single-entry output register that never bubbles under continuous out_ready.
module viterbi_encoder_stream
    import conv_code_pkg::*;
#(
    parameter int          K         = CONV_K,
    parameter logic [K-1:0] G1       = CONV_G1,
    parameter logic [K-1:0] G2       = CONV_G2,
    parameter int unsigned FRAME_LEN = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       out_valid,
    output logic [5:0] out_data,
    output logic       out_last,
    input  logic       out_ready
);

    localparam int TW = (K > 2) ? $clog2(K - 1) : 1;

    enc_state_t    r_state;
    enc_state_t    w_state_nxt;
    logic [15:0]   r_bit_cnt;
    logic [TW-1:0] r_tail_cnt;
    logic          r_out_valid;
    logic [5:0]    r_out_data;
    logic          r_out_last;

    logic          w_slot_free;
    logic          w_step;
    logic          w_b;
    logic          w_data_end;
    logic          w_tail_end;
    logic          w_c1;
    logic          w_c2;
    logic [5:0]    w_word;

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_step      = w_slot_free && ((r_state == ST_TAIL) || in_valid);
    assign w_b         = (r_state == ST_DATA) ? in_bit : 1'b0;
    assign w_data_end  = (r_state == ST_DATA) && (r_bit_cnt == 16'(FRAME_LEN - 1));
    assign w_tail_end  = (r_state == ST_TAIL) && (r_tail_cnt == TW'(K - 2));
    assign w_word      = {soft_map(w_c2), soft_map(w_c1)};

    assign in_ready  = (r_state == ST_DATA) && w_slot_free;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

    // The tail already flushes sr to zero; the clear only pins the frame boundary.
    conv_enc_core #(
        .K  (K),
        .G1 (G1),
        .G2 (G2)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .step  (w_step),
        .b     (w_b),
        .clear (w_step && w_tail_end),
        .c1    (w_c1),
        .c2    (w_c2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_DATA;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_DATA: if (w_step && w_data_end) w_state_nxt = ST_TAIL;
            ST_TAIL: if (w_step && w_tail_end) w_state_nxt = ST_DATA;
            default: w_state_nxt = ST_DATA;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt  <= '0;
            r_tail_cnt <= '0;
        end else if (w_step) begin
            if (r_state == ST_DATA) begin
                r_bit_cnt <= w_data_end ? '0 : r_bit_cnt + 16'd1;
            end else begin
                r_tail_cnt <= w_tail_end ? '0 : r_tail_cnt + TW'(1);
            end
        end
    end

    // A step overwrites the slot even while the old word is being consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_step) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_word;
            r_out_last  <= w_tail_end;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_viterbi_encoder_stream.sv
// Directed bench: instance A uses FRAME_LEN=1, instance B uses FRAME_LEN=8.
module tb_viterbi_encoder_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       a_in_valid, a_in_bit, a_in_ready, a_out_valid, a_out_last, a_out_ready;
    logic [5:0] a_out_data;
    logic       b_in_valid, b_in_bit, b_in_ready, b_out_valid, b_out_last, b_out_ready;
    logic [5:0] b_out_data;

    int errors = 0;
    int checks = 0;

    logic [7:0] frames [3];
    logic [5:0] exp_w [$];
    logic       exp_l [$];
    logic [5:0] got_w [$];
    logic       got_l [$];

    always #5 clk = ~clk;

    viterbi_encoder_stream #(.FRAME_LEN(1)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_bit(a_in_bit), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_last(a_out_last),
        .out_ready(a_out_ready)
    );

    viterbi_encoder_stream #(.FRAME_LEN(8)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_bit(b_in_bit), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last),
        .out_ready(b_out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference: 8 info bits (bit i sent i-th) followed by 6 zero tail bits.
    task automatic model_frame(input logic [7:0] bits);
        logic [5:0] sr;
        logic [6:0] v;
        logic       bb, c1, c2;
        sr = 6'b0;
        for (int i = 0; i < 14; i++) begin
            bb = (i < 8) ? bits[i] : 1'b0;
            v  = {bb, sr};
            c1 = ^(v & 7'o171);
            c2 = ^(v & 7'o133);
            exp_w.push_back({{3{c2}}, {3{c1}}});
            exp_l.push_back(i == 13);
            sr = {bb, sr[5:1]};
        end
    endtask

    task automatic run_stream(input int nframes, input bit stall_mode);
        int nbits, nexp, idx, cyc, lasts;
        logic [5:0] held;
        bit held_ok;
        nbits = nframes * 8;
        nexp  = nframes * 14;
        idx = 0; cyc = 0; lasts = 0; held = '0; held_ok = 0;
        got_w.delete();
        got_l.delete();
        while (got_w.size() < nexp && cyc < 2000) begin
            @(negedge clk);
            if (stall_mode) begin
                b_out_ready = !(cyc >= 4 && cyc < 9);
                b_in_valid  = (idx < nbits);
            end else begin
                b_out_ready = 1'($urandom_range(0, 1));
                b_in_valid  = (idx < nbits) && (1'($urandom_range(0, 1)));
            end
            b_in_bit = (idx < nbits) ? frames[idx / 8][idx % 8] : 1'b0;
            #1;
            if (stall_mode && !b_out_ready) begin
                if (!held_ok) begin
                    held = b_out_data;
                    held_ok = 1;
                end else begin
                    chk("stall_hold", b_out_data, held);
                end
                chk("stall_in_ready", b_in_ready, 1'b0);
            end
            if (b_out_valid && b_out_ready) begin
                got_w.push_back(b_out_data);
                got_l.push_back(b_out_last);
                if (b_out_last) lasts++;
            end
            if (b_in_valid && b_in_ready) idx++;
            cyc++;
        end
        chk("stream_words", got_w.size(), nexp);
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            chk($sformatf("stream_word%0d", i), got_w[i], exp_w[i]);
            chk($sformatf("stream_last%0d", i), got_l[i], exp_l[i]);
        end
        if (!stall_mode) chk("last_pulses", lasts, nframes);
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
    endtask

    logic [5:0] imp [7];

    initial begin
        imp[0] = 6'b111111; imp[1] = 6'b000111; imp[2] = 6'b111111; imp[3] = 6'b111111;
        imp[4] = 6'b000000; imp[5] = 6'b111000; imp[6] = 6'b111111;
        a_in_valid = 0; a_in_bit = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_bit = 0; b_out_ready = 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset while a word is held
        @(negedge clk);
        b_in_valid = 1; b_in_bit = 1; b_out_ready = 0;
        @(negedge clk);
        b_in_valid = 0;
        chk("pre_rst_valid", b_out_valid, 1'b1);
        chk("pre_rst_data", b_out_data, 6'b111111);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", b_out_valid, 1'b0);
        chk("rst_data", b_out_data, 6'b0);
        chk("rst_last", b_out_last, 1'b0);
        chk("rst_in_ready_or0", b_in_ready, 1'b1);
        b_out_ready = 1;
        #1;
        chk("rst_in_ready_or1", b_in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Impulse response, FRAME_LEN=1
        @(negedge clk);
        a_in_valid = 1; a_in_bit = 1;
        #1 chk("imp_in_ready0", a_in_ready, 1'b1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            a_in_valid = 0;
            #1;
            chk($sformatf("imp_valid%0d", i), a_out_valid, 1'b1);
            chk($sformatf("imp_word%0d", i), a_out_data, imp[i]);
            chk($sformatf("imp_last%0d", i), a_out_last, i == 6);
            chk($sformatf("imp_in_ready%0d", i), a_in_ready, i == 6);
        end
        @(negedge clk);
        #1 chk("imp_drained", a_out_valid, 1'b0);

        // All-zero throughput, FRAME_LEN=8, then next frame starts without a gap
        do_reset();
        @(negedge clk);
        b_out_ready = 1; b_in_valid = 1; b_in_bit = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("zero_valid%0d", i), b_out_valid, 1'b1);
            chk($sformatf("zero_word%0d", i), b_out_data, 6'b0);
            chk($sformatf("zero_last%0d", i), b_out_last, i == 13);
            if (i == 13) begin
                chk("zero_next_ready", b_in_ready, 1'b1);
                b_in_bit = 1;
            end
        end
        @(negedge clk);
        #1;
        chk("next_frame_valid", b_out_valid, 1'b1);
        chk("next_frame_word", b_out_data, 6'b111111);
        chk("next_frame_last", b_out_last, 1'b0);
        b_in_valid = 0;

        // Backpressure mid-frame
        do_reset();
        frames[0] = 8'b1011_0010;
        exp_w.delete(); exp_l.delete();
        model_frame(frames[0]);
        run_stream(1, 1);

        // Random handshakes over three frames
        do_reset();
        frames[0] = 8'b1100_1011;
        frames[1] = 8'b0001_0111;
        frames[2] = 8'b1110_0100;
        exp_w.delete(); exp_l.delete();
        for (int f = 0; f < 3; f++) model_frame(frames[f]);
        run_stream(3, 0);

        // Reset during the third tail step discards the frame and its history
        do_reset();
        @(negedge clk);
        a_out_ready = 1; a_in_valid = 1; a_in_bit = 1;
        @(negedge clk);
        a_in_valid = 0;
        @(negedge clk);
        @(negedge clk);
        #1 chk("tail_in_ready", a_in_ready, 1'b0);
        rst = 1'b1;
        #1 chk("tail_rst_valid", a_out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        a_in_valid = 1; a_in_bit = 1;
        #1 chk("post_rst_in_ready", a_in_ready, 1'b1);
        @(negedge clk);
        a_in_valid = 0;
        #1;
        chk("post_rst_valid", a_out_valid, 1'b1);
        chk("post_rst_word", a_out_data, 6'b111111);
        chk("post_rst_last", a_out_last, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/viterbi_encoder_stream.md
# viterbi_encoder_stream

Rate-1/2 convolutional encoder for the transmit side of the Viterbi link. It sits ahead of the UART transmitter configured with `DATA_WIDTH=6`. It accepts information bits over a valid/ready handshake and appends K-1 zero tail bits after every `FRAME_LEN` bits. It emits one 6-bit word per trellis step, packed exactly as `viterbi_decoder` consumes it: `[2:0]` = y1, `[5:3]` = y2, each a 3-bit soft value.

## Interface
- `K`, default 7: constraint length; shift register holds K-1 bits.
- `G1`, default 7'o171: generator for y1; MSB taps the current input bit.
- `G2`, default 7'o133: generator for y2; MSB taps the current input bit.
- `FRAME_LEN`, default 64: information bits per frame, range 1..65535.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  `in_bit` is presented.
- `in_bit`  in  1  information bit.
- `in_ready`  out  1  encoder accepts `in_bit` this cycle.
- `out_valid`  out  1  `out_data` holds a coded word.
- `out_data`  out  6  {y2[2:0], y1[2:0]}.
- `out_last`  out  1  qualifies the final tail word of a frame.
- `out_ready`  in  1  sink consumes `out_data` this cycle.

## Operation
- **Encoder state:** `sr[K-2:0]`, with `sr[K-2]` the most recent bit.
- **Step with bit b:**
  - form v = {b, sr};
  - c1 = ^(v & G1), c2 = ^(v & G2);
  - shift sr ← {b, sr[K-2:1]}.
- **Soft mapping:** coded 0 → 3'b000, coded 1 → 3'b111. out_data = {map(c2), map(c1)}.
- **FSM states:**
  - DATA: steps use accepted `in_bit`. `bit_cnt` counts accepted bits. On the FRAME_LEN-th accept, go to TAIL and clear `bit_cnt`.
  - TAIL: steps use b = 0 whenever the output slot is free; `in_valid` is ignored. `tail_cnt` counts 0..K-2. On step K-1, set `out_last`, go to DATA and clear `tail_cnt`. `sr` is all-zero on return to DATA.
- **Output slot:** a single output register.
  - slot_free = !out_valid || out_ready.
  - A step fires when slot_free and (TAIL, or DATA with in_valid). A firing step loads `out_data`/`out_last` and sets `out_valid`.
  - If out_ready && out_valid and no step fires, clear `out_valid`.
- **in_ready:** in_ready = (state == DATA) && slot_free. It is combinational from `out_ready`; there is no combinational path from `in_valid`.
- **Frame size:** each frame emits exactly FRAME_LEN + K - 1 words, in order, with no drops or duplicates.
- **Reset at any time:** returns to DATA and clears `sr`, the counters and the output register. A partial frame is discarded.

## Timing
- **Reset values:**
  - `out_valid` = 0, `out_data` = 6'b0, `out_last` = 0;
  - `in_ready` = 1 while `out_ready` is any value, because the slot is empty.
- **Latency:** the word for a bit accepted in cycle n is valid in cycle n+1.
- **Throughput:** one word per cycle while `out_ready` = 1, including the DATA→TAIL and TAIL→DATA boundaries; there are no bubbles.
- **Backpressure:** while out_valid && !out_ready, `out_data` and `out_last` are held stable and no step fires.
- **Simultaneous consume and step:** the word is replaced and `out_valid` stays 1.
- **Start of next frame:** the first DATA step can fire in the same cycle the last tail word is consumed.

## Structure
- **Package `conv_code_pkg`:**
  - default K, G1, G2 (shared with `viterbi_decoder`);
  - `SOFT_ZERO`, `SOFT_ONE`;
  - the DATA/TAIL state enum;
  - a function returning the 6-bit word for (v, G1, G2).
- **Sub-module `conv_enc_core`:**
  - holds `sr`;
  - inputs: `step`, `b`, `clear`;
  - outputs: c1, c2 for the current v.
- **Top:** FSM, counters and the output register.

## Test plan
- **Reset:** assert `rst` mid-cycle, asynchronously.
  - Required: `out_valid` = 0, `out_data` = 0 and `out_last` = 0 immediately; `in_ready` = 1.
- **Impulse response:** FRAME_LEN = 1, defaults, `out_ready` = 1, input bit 1.
  - Required: 7 consecutive words 6'b111111, 6'b000111, 6'b111111, 6'b111111, 6'b000000, 6'b111000, 6'b111111.
  - `out_last` set only on the 7th word; `in_ready` low for exactly 6 cycles.
- **All-zero throughput:** FRAME_LEN = 8, bits all 0, `out_ready` = 1.
  - Required: 14 words of 6'b000000 on 14 consecutive cycles; `out_last` on word 14; next frame accepted on the following cycle.
- **Backpressure:** drop `out_ready` for 5 cycles mid-frame.
  - Required: `out_data` stable, `in_ready` = 0, and the final word sequence identical to the unstalled run.
- **Random bursts:** random `in_valid` and `out_ready` over 3 frames.
  - Required: output matches a reference model word-for-word; exactly 3 `out_last` pulses.
- **Reset mid-tail:** assert `rst` during TAIL step 3.
  - Required: the next frame's first word depends only on its own bit, e.g. bit 1 → 6'b111111.
